// File: rtl/gng_pkg.sv
// Shared constants, types and taus88 helpers for the CLT Gaussian noise generator.
package gng_pkg;

  localparam logic [31:0] KSEED_1      = 32'h9E37_79B9;
  localparam logic [31:0] KSEED_2      = 32'h85EB_CA6B;
  localparam logic [31:0] KSEED_3      = 32'hC2B2_AE35;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  localparam logic [31:0] TAUS_MASK1 = 32'hFFFF_FFFE;
  localparam logic [31:0] TAUS_MASK2 = 32'hFFFF_FFF8;
  localparam logic [31:0] TAUS_MASK3 = 32'hFFFF_FFF0;

  localparam int TAUS_S1_A = 12;
  localparam int TAUS_S1_B = 13;
  localparam int TAUS_S1_C = 19;
  localparam int TAUS_S2_A = 4;
  localparam int TAUS_S2_B = 2;
  localparam int TAUS_S2_C = 25;
  localparam int TAUS_S3_A = 17;
  localparam int TAUS_S3_B = 3;
  localparam int TAUS_S3_C = 11;

  // Minimum legal component values; below these the taus88 component degenerates.
  localparam logic [31:0] TAUS_MIN1 = 32'd2;
  localparam logic [31:0] TAUS_MIN2 = 32'd8;
  localparam logic [31:0] TAUS_MIN3 = 32'd16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } gng_state_e;

  typedef struct packed {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] s3;
  } taus_state_t;

  function automatic taus_state_t taus_step(input taus_state_t s);
    taus_state_t r;
    r.s1 = ((s.s1 & TAUS_MASK1) << TAUS_S1_A) ^ (((s.s1 << TAUS_S1_B) ^ s.s1) >> TAUS_S1_C);
    r.s2 = ((s.s2 & TAUS_MASK2) << TAUS_S2_A) ^ (((s.s2 << TAUS_S2_B) ^ s.s2) >> TAUS_S2_C);
    r.s3 = ((s.s3 & TAUS_MASK3) << TAUS_S3_A) ^ (((s.s3 << TAUS_S3_B) ^ s.s3) >> TAUS_S3_C);
    return r;
  endfunction

  function automatic logic [31:0] taus_out(input taus_state_t s);
    return s.s1 ^ s.s2 ^ s.s3;
  endfunction

  // chan_mul is the 1-based channel index, so each channel gets a distinct stream.
  function automatic taus_state_t taus_seed(input logic [31:0] seed, input logic [31:0] chan_mul);
    taus_state_t r;
    r.s1 = seed ^ (KSEED_1 * chan_mul);
    r.s2 = seed ^ (KSEED_2 * chan_mul);
    r.s3 = seed ^ (KSEED_3 * chan_mul);
    if (r.s1 < TAUS_MIN1) r.s1 = r.s1 | TAUS_MIN1;
    if (r.s2 < TAUS_MIN2) r.s2 = r.s2 | TAUS_MIN2;
    if (r.s3 < TAUS_MIN3) r.s3 = r.s3 | TAUS_MIN3;
    return r;
  endfunction

endpackage

// File: rtl/gng_taus88.sv
// One taus88 uniform generator channel: state registers, step, seed load and sanitisation.
module gng_taus88
  import gng_pkg::*;
#(
  parameter int CH_IDX = 0,
  parameter int OUT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  input  logic             step,
  output logic [OUT_W-1:0] term
);

  localparam logic [31:0] CH_MUL = 32'(CH_IDX + 1);

  taus_state_t state_q;
  taus_state_t state_d;
  taus_state_t state_next;

  always_comb begin
    state_next = taus_step(state_q);
    state_d    = state_q;
    if (seed_load) begin
      state_d = taus_seed(seed_in, CH_MUL);
    end else if (step) begin
      state_d = state_next;
    end
  end

  // The term is the top OUT_W bits of the output produced by the upcoming step.
  assign term = OUT_W'(taus_out(state_next) >> (32 - OUT_W));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= taus_seed(DEFAULT_SEED, CH_MUL);
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/gng_clt.sv
// Multi-channel Gaussian noise generator: sums NSUM taus88 uniforms per sample (central limit)
// and presents the centred, scaled result through a valid/ready hold stage.
module gng_clt
  import gng_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int OUT_W  = 16,
  parameter int NSUM   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    seed_load,
  input  logic [31:0]             seed_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data
);

  localparam int LOG2N = $clog2(NSUM);
  localparam int ACC_W = OUT_W + LOG2N;
  localparam int CNT_W = LOG2N;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSUM - 1);
  // NSUM * 2^(OUT_W-1) is exactly the MSB weight of the accumulator.
  localparam logic [ACC_W-1:0] ACC_BIAS = ACC_W'(1) << (ACC_W - 1);

  gng_state_e              state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [ACC_W-1:0]        acc_q [NUM_CH];
  logic [ACC_W-1:0]        acc_d [NUM_CH];
  logic [ACC_W-1:0]        acc_sum [NUM_CH];
  logic [OUT_W-1:0]        term_w [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] sample_w;
  logic [NUM_CH*OUT_W-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    step;

  assign step = (state_q == ST_ACCUM) && en && !seed_load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gng_taus88 #(
      .CH_IDX (c),
      .OUT_W  (OUT_W)
    ) u_taus (
      .clk       (clk),
      .reset     (reset),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .step      (step),
      .term      (term_w[c])
    );
  end

  // Arithmetic shift then truncation keeps the top OUT_W bits of the centred sum.
  always_comb begin
    sample_w = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      acc_sum[c] = acc_q[c] + ACC_W'(term_w[c]);
      sample_w[c*OUT_W +: OUT_W] = OUT_W'($signed(acc_sum[c] - ACC_BIAS) >>> LOG2N);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    valid_d = valid_q;
    data_d  = data_q;
    for (int c = 0; c < NUM_CH; c++) acc_d[c] = acc_q[c];

    if (seed_load) begin
      state_d = ST_ACCUM;
      count_d = '0;
      valid_d = 1'b0;
      data_d  = '0;
      for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (en) begin
            count_d = count_q + CNT_W'(1);
            for (int c = 0; c < NUM_CH; c++) acc_d[c] = acc_sum[c];
            if (count_q == CNT_LAST) begin
              state_d = ST_HOLD;
              count_d = '0;
              valid_d = 1'b1;
              data_d  = sample_w;
              for (int c = 0; c < NUM_CH; c++) acc_d[c] = '0;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state_d = ST_ACCUM;
            valid_d = 1'b0;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ACCUM;
      count_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      for (int c = 0; c < NUM_CH; c++) acc_q[c] <= acc_d[c];
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_gng_clt.sv
// Self-checking bench for gng_clt: independent taus88/CLT model feeding a scoreboard queue,
// a table of reseed scenarios, and hand-written reset/abort sequences.
module tb_gng_clt;

  localparam int NUM_CH = 2;
  localparam int OUT_W  = 16;
  localparam int NSUM   = 4;
  localparam int LOG2N  = 2;
  localparam int DW     = NUM_CH * OUT_W;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          seed_load;
  logic [31:0]   seed_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  always #5 clk = ~clk;

  gng_clt #(
    .NUM_CH (NUM_CH),
    .OUT_W  (OUT_W),
    .NSUM   (NSUM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] held;

  logic [31:0] m_s1 [NUM_CH];
  logic [31:0] m_s2 [NUM_CH];
  logic [31:0] m_s3 [NUM_CH];

  typedef struct {
    logic [31:0] seed;
    int          n_samples;
    int          stall;
    int          gap_len;
    int          exp_lat;
  } vec_t;

  vec_t vecs [4];

  // Reference model: reseed every channel from a seed word with sanitisation.
  function automatic void model_seed(input logic [31:0] seed);
    for (int c = 0; c < NUM_CH; c++) begin
      logic [31:0] mul;
      mul = 32'(c + 1);
      m_s1[c] = seed ^ (32'h9E3779B9 * mul);
      m_s2[c] = seed ^ (32'h85EBCA6B * mul);
      m_s3[c] = seed ^ (32'hC2B2AE35 * mul);
      if (m_s1[c] < 32'd2)  m_s1[c] = m_s1[c] | 32'd2;
      if (m_s2[c] < 32'd8)  m_s2[c] = m_s2[c] | 32'd8;
      if (m_s3[c] < 32'd16) m_s3[c] = m_s3[c] | 32'd16;
    end
  endfunction

  // Reference model: one taus88 step of channel c, returning the new uniform word.
  function automatic logic [31:0] model_u(input int c);
    m_s1[c] = ((m_s1[c] & 32'hFFFFFFFE) << 12) ^ (((m_s1[c] << 13) ^ m_s1[c]) >> 19);
    m_s2[c] = ((m_s2[c] & 32'hFFFFFFF8) << 4)  ^ (((m_s2[c] << 2)  ^ m_s2[c]) >> 25);
    m_s3[c] = ((m_s3[c] & 32'hFFFFFFF0) << 17) ^ (((m_s3[c] << 3)  ^ m_s3[c]) >> 11);
    return m_s1[c] ^ m_s2[c] ^ m_s3[c];
  endfunction

  // Reference model: next packed sample, computed with plain integer arithmetic.
  function automatic logic [DW-1:0] model_sample();
    logic [DW-1:0] r;
    r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      int sum;
      int val;
      sum = 0;
      for (int k = 0; k < NSUM; k++) sum += int'(model_u(c) >> (32 - OUT_W));
      val = (sum - NSUM * (1 << (OUT_W - 1))) >>> LOG2N;
      r[c*OUT_W +: OUT_W] = val[OUT_W-1:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Single-cycle reseed pulse; the model is reseeded alongside.
  task automatic applyStimulus(input logic [31:0] seed);
    seed_load = 1'b1;
    seed_in   = seed;
    @(posedge clk); #1;
    seed_load = 1'b0;
    model_seed(seed);
    checkOutput("seed_drops_valid", 64'(out_valid), 64'd0);
  endtask

  // Push the expected sample, then count edges until out_valid, optionally pausing en.
  task automatic waitSample(input int gap_at, input int gap_len, input int exp_lat);
    int edges;
    bit seen;
    edges = 0;
    seen  = 1'b0;
    exp_q.push_back(model_sample());
    while (!seen && edges < exp_lat + 8) begin
      if (gap_len > 0 && edges == gap_at) en = 1'b0;
      if (edges == gap_at + gap_len) en = 1'b1;
      @(posedge clk); #1;
      edges++;
      if (out_valid) seen = 1'b1;
    end
    en = 1'b1;
    checkOutput("valid_latency", 64'(edges), 64'(exp_lat));
    held = exp_q.pop_front();
    checkOutput("sample_data", 64'(out_data), 64'(held));
  endtask

  task automatic acceptSample();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("valid_fall", 64'(out_valid), 64'd0);
  endtask

  task automatic stallCheck(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", 64'(out_valid), 64'd1);
      checkOutput("hold_data", 64'(out_data), 64'(held));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reseed scenarios: seed word, samples, HOLD stall length, en gap length, expected latency.
    vecs[0] = '{32'h0000_0000, 2, 20, 0, NSUM};
    vecs[1] = '{32'hDEAD_BEEF, 3, 0,  5, NSUM + 5};
    vecs[2] = '{32'h1234_5678, 3, 3,  2, NSUM + 2};
    vecs[3] = '{32'hFFFF_FFFF, 2, 0,  0, NSUM};

    reset     = 1'b1;
    en        = 1'b0;
    seed_load = 1'b0;
    seed_in   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_data", 64'(out_data), 64'd0);

    // Long free run from the default seed, first sample NSUM edges after reset release.
    model_seed(32'h0000_0001);
    reset = 1'b0;
    en    = 1'b1;
    for (int s = 0; s < 1000; s++) begin
      waitSample(0, 0, NSUM);
      acceptSample();
    end

    // Leave a sample in HOLD so the first reseed lands during HOLD.
    waitSample(0, 0, NSUM);

    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].seed);
      for (int s = 0; s < vecs[v].n_samples; s++) begin
        if (s == 0) waitSample(2, vecs[v].gap_len, vecs[v].exp_lat);
        else        waitSample(0, 0, NSUM);
        if (vecs[v].seed == 32'h0 && s == 0)
          checkOutput("seed0_nonzero", 64'(out_data != '0), 64'd1);
        if (vecs[v].stall > 0) begin
          en = 1'b0;
          stallCheck(vecs[v].stall);
        end
        if (s < vecs[v].n_samples - 1) begin
          acceptSample();
          en = 1'b1;
        end
      end
      en = 1'b1;
    end

    // Reset at count=2 aborts the sample; the sequence restarts from the default seed.
    acceptSample();
    en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midreset_valid", 64'(out_valid), 64'd0);
    checkOutput("midreset_data", 64'(out_data), 64'd0);
    reset = 1'b0;
    model_seed(32'h0000_0001);
    for (int s = 0; s < 3; s++) begin
      waitSample(0, 0, NSUM);
      acceptSample();
    end

    // Reset while in HOLD discards the held sample.
    waitSample(0, 0, NSUM);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("holdreset_valid", 64'(out_valid), 64'd0);
    checkOutput("holdreset_data", 64'(out_data), 64'd0);
    reset = 1'b0;
    model_seed(32'h0000_0001);
    waitSample(0, 0, NSUM);
    acceptSample();

    if (exp_q.size() != 0) checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
